ahb3lite_sram_ws: RTL and testbench

- Next-generation AHB3-Lite SRAM slave.
- Generalised in data width (32/64/128), memory depth and programmable wait states.
- Adds two-cycle ERROR responses for out-of-range address or oversize HSIZE, which the current slave never produces.
- Sits on the AHB3-Lite interconnect as a bus-attached scratch RAM; internal byte-enable write-forwarding keeps reads coherent.

---
 rtl/ahb3lite_pkg.sv | 31 +++
 rtl/ahb3lite_sram_mem.sv | 29 ++
 rtl/ahb3lite_sram_ws.sv | 181 ++++++++++++++++++
 tb/tb_ahb3lite_sram_ws.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: shared AHB3-Lite encodings, SRAM slave state type and
// transfer-size legality helper.
package ahb3lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;
   localparam logic [2:0] HSIZE_B128  = 3'b100;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {IDLE, WAIT, ERR1, ERR2, OKAY} sram_state_t;

   // A transfer may not be wider than the data bus.
   function automatic logic size_legal(input logic [2:0] hsize, input int unsigned hdata_size);
      return int'(hsize) <= $clog2(hdata_size / 8);
   endfunction

endpackage

// File: rtl/ahb3lite_sram_mem.sv
// ahb3lite_sram_mem: word-organised RAM, synchronous byte-enabled write,
// read port driven by the registered data-phase word address.
module ahb3lite_sram_mem #(
   parameter int unsigned ABITS = 8,
   parameter int unsigned DBITS = 32
) (
   input  logic                 HCLK,
   input  logic                 we,
   input  logic [DBITS/8-1:0]   be,
   input  logic [ABITS-1:0]     waddr,
   input  logic [DBITS-1:0]     wdata,
   input  logic [ABITS-1:0]     raddr,
   output logic [DBITS-1:0]     rdata
);

   logic [DBITS-1:0] mem [2**ABITS];

   // Byte-lane write of the committed word.
   always_ff @(posedge HCLK) begin
      if (we) begin
         for (int unsigned i = 0; i < DBITS/8; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ahb3lite_sram_ws.sv
// ahb3lite_sram_ws: AHB3-Lite SRAM slave with programmable wait states,
// two-cycle ERROR responses and write forwarding for read coherency.
// Optional macro AHB_SRAM_PROT_EN: unprivileged writes at or above word
// PROT_BASE are rejected with ERROR.
module ahb3lite_sram_ws
   import ahb3lite_pkg::*;
#(
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned HADDR_SIZE  = 16,
   parameter int unsigned HDATA_SIZE  = 32,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned PROT_BASE   = 'h0080
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   output logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int unsigned     DBYTES    = HDATA_SIZE / 8;
   localparam int unsigned     ALSB      = $clog2(DBYTES);
   localparam int unsigned     ABITS     = $clog2(MEM_DEPTH);
   localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH) * DBYTES;

   sram_state_t       state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              accept;
   logic              err_d;
   logic [ABITS-1:0]  word_d, addr_q;
   logic [DBYTES-1:0] be_d, be_q;
   logic              wr_q;
   logic              data_done;

   logic                  pend_vld;
   logic [ABITS-1:0]      pend_addr;
   logic [DBYTES-1:0]     pend_be;
   logic [HDATA_SIZE-1:0] pend_data;
   logic [HDATA_SIZE-1:0] mem_rdata, merged;
   logic                  unused_bits;

   assign accept = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ)
                   && (state == IDLE || state == OKAY);
   assign word_d    = HADDR[ALSB +: ABITS];
   assign data_done = (state == OKAY) && wr_q;

   // Address-phase error decode: out of range, oversize, optional protection.
   always_comb begin
      err_d = (64'(HADDR) >= MEM_BYTES) || !size_legal(HSIZE, HDATA_SIZE);
`ifdef AHB_SRAM_PROT_EN
      if (HWRITE && !HPROT[1] && (32'(word_d) >= PROT_BASE)) err_d = 1'b1;
`endif
   end

`ifdef AHB_SRAM_PROT_EN
   assign unused_bits = ^{HBURST, HPROT};
`else
   assign unused_bits = ^{HBURST, HPROT, PROT_BASE};
`endif

   // Byte enables: lanes sharing the size-aligned chunk of the low address.
   always_comb begin
      be_d = '0;
      for (int unsigned i = 0; i < DBYTES; i++) begin
         be_d[i] = ((i >> HSIZE) == (32'(HADDR[ALSB-1:0]) >> HSIZE));
      end
   end

   // Capture the accepted address phase for the data phase.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_q <= '0;
         be_q   <= '0;
         wr_q   <= 1'b0;
      end else if (accept) begin
         addr_q <= word_d;
         be_q   <= be_d;
         wr_q   <= HWRITE;
      end
   end

   // FSM state and wait-counter register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state, wait countdown and bus response outputs.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      case (state)
         IDLE, OKAY: begin
            state_nxt = IDLE;
            if (accept) begin
               if (err_d) begin
                  state_nxt = ERR1;
               end else if (WAIT_STATES == 0) begin
                  state_nxt = OKAY;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = 4'(WAIT_STATES - 1);
               end
            end
         end
         WAIT: begin
            HREADYOUT = 1'b0;
            if (cnt == '0) state_nxt = OKAY;
            else           cnt_nxt   = cnt - 4'd1;
         end
         ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            state_nxt = ERR2;
         end
         ERR2: begin
            HRESP     = HRESP_ERROR;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Hold the sampled write for one cycle; it commits on the next clock.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pend_vld  <= 1'b0;
         pend_addr <= '0;
         pend_be   <= '0;
         pend_data <= '0;
      end else begin
         pend_vld <= data_done;
         if (data_done) begin
            pend_addr <= addr_q;
            pend_be   <= be_q;
            pend_data <= HWDATA;
         end
      end
   end

   ahb3lite_sram_mem #(
      .ABITS (ABITS),
      .DBITS (HDATA_SIZE)
   ) u_mem (
      .HCLK  (HCLK),
      .we    (pend_vld),
      .be    (pend_be),
      .waddr (pend_addr),
      .wdata (pend_data),
      .raddr (addr_q),
      .rdata (mem_rdata)
   );

   // Read data: pending bytes overlay memory bytes while the commit is in flight.
   always_comb begin
      merged = mem_rdata;
      if (pend_vld && pend_addr == addr_q) begin
         for (int unsigned i = 0; i < DBYTES; i++) begin
            if (pend_be[i]) merged[8*i +: 8] = pend_data[8*i +: 8];
         end
      end
      HRDATA = (state == OKAY && !wr_q) ? merged : '0;
   end

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// tb_ahb3lite_sram_ws: two slaves (0 and 3 wait states) on a shared bus,
// checked against a byte-level memory model.
module tb_ahb3lite_sram_ws;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        hsel = 1'b0;
   logic [15:0] haddr = '0;
   logic [31:0] hwdata = '0;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'd2;
   logic [2:0]  hburst = 3'd0;
   logic [3:0]  hprot = 4'b0011;
   logic [1:0]  htrans = 2'b00;
   logic        use3 = 1'b0;

   logic        hro0, hro3, hresp0, hresp3;
   logic [31:0] hrd0, hrd3;
   logic        hready, hresp_m;
   logic [31:0] hrdata_m;

   int errors = 0;
   int checks = 0;

   logic [31:0] mdl [2][256];

   bit          op_w [64];
   logic [15:0] op_a [64];
   logic [2:0]  op_s [64];
   logic [31:0] op_d [64];
   logic [31:0] res_d [64];
   logic        res_resp [64];
   logic        res_r1 [64];
   int          res_waits [64];

   always #5 HCLK = ~HCLK;

   assign hready   = use3 ? hro3 : hro0;
   assign hresp_m  = use3 ? hresp3 : hresp0;
   assign hrdata_m = use3 ? hrd3 : hrd0;

   ahb3lite_sram_ws #(.MEM_DEPTH(256), .HADDR_SIZE(16), .HDATA_SIZE(32), .WAIT_STATES(0)) u0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & ~use3), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(hrd0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HREADY(hro0), .HREADYOUT(hro0), .HRESP(hresp0));

   ahb3lite_sram_ws #(.MEM_DEPTH(256), .HADDR_SIZE(16), .HDATA_SIZE(32), .WAIT_STATES(3)) u3 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & use3), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(hrd3), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HREADY(hro3), .HREADYOUT(hro3), .HRESP(hresp3));

   // Reference write: 2**size bytes starting at the size-aligned lane.
   task automatic model_write(input int d, input logic [15:0] a, input logic [2:0] s, input logic [31:0] data);
      int nb, base, lane;
      nb   = 1 << s;
      base = int'(a[1:0]) & ~(nb - 1);
      for (int b = 0; b < nb; b++) begin
         lane = base + b;
         mdl[d][a[9:2]][8*lane +: 8] = data[8*lane +: 8];
      end
   endtask

   // Drive ops 0..n-1 fully pipelined and record each data-phase result.
   task automatic run_seq(input int n);
      int  w;
      bit  done;
      @(negedge HCLK);
      hsel = 1'b1; htrans = 2'b10;
      haddr = op_a[0]; hwrite = op_w[0]; hsize = op_s[0];
      @(posedge HCLK);
      for (int k = 0; k < n; k++) begin
         #1;
         hwdata = op_d[k];
         if (k + 1 < n) begin
            haddr = op_a[k+1]; hwrite = op_w[k+1]; hsize = op_s[k+1]; htrans = 2'b10;
         end else begin
            htrans = 2'b00;
         end
         w = 0; done = 1'b0; res_r1[k] = 1'b0;
         while (!done) begin
            @(negedge HCLK);
            if (w == 0) res_r1[k] = hresp_m;
            if (hready) begin
               res_d[k] = hrdata_m; res_resp[k] = hresp_m; done = 1'b1;
            end else if (w >= 40) begin
               checks++; errors++;
               $display("FAIL timeout op %0d: HREADYOUT low %0d cycles, required <= 40", k, w);
               done = 1'b1;
            end else begin
               w++;
            end
            @(posedge HCLK);
         end
         res_waits[k] = w;
      end
   endtask

   task automatic set_op(input int k, input bit w, input logic [15:0] a, input logic [2:0] s, input logic [31:0] d);
      op_w[k] = w; op_a[k] = a; op_s[k] = s; op_d[k] = d;
   endtask

   task automatic init_mem(input int d);
      use3 = (d == 1);
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 64; k++) set_op(k, 1'b1, 16'((c*64 + k) * 4), 3'd2, $urandom);
         run_seq(64);
         for (int k = 0; k < 64; k++) model_write(d, op_a[k], op_s[k], op_d[k]);
      end
   endtask

   task automatic test_reset();
      #3;
      checks++; if (hro0 !== 1'b1)  begin errors++; $display("FAIL reset_hready0: got %b exp 1", hro0); end
      checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL reset_hresp0: got %b exp 0", hresp0); end
      checks++; if (hrd0 !== 32'h0)  begin errors++; $display("FAIL reset_hrdata0: got %h exp 0", hrd0); end
      checks++; if (hro3 !== 1'b1)  begin errors++; $display("FAIL reset_hready3: got %b exp 1", hro3); end
      checks++; if (hresp3 !== 1'b0) begin errors++; $display("FAIL reset_hresp3: got %b exp 0", hresp3); end
      checks++; if (hrd3 !== 32'h0)  begin errors++; $display("FAIL reset_hrdata3: got %h exp 0", hrd3); end
      @(negedge HCLK); HRESETn = 1'b1;
   endtask

   task automatic test_ws0_write_read();
      use3 = 1'b0;
      set_op(0, 1'b1, 16'h0010, 3'd2, 32'hDEADBEEF);
      set_op(1, 1'b0, 16'h0010, 3'd2, 32'h0);
      run_seq(2);
      model_write(0, 16'h0010, 3'd2, 32'hDEADBEEF);
      for (int k = 0; k < 2; k++) begin
         checks++; if (res_waits[k] !== 0) begin errors++; $display("FAIL ws0_waits op%0d: got %0d exp 0", k, res_waits[k]); end
      end
      checks++; if (res_resp[1] !== 1'b0) begin errors++; $display("FAIL ws0_resp: got %b exp 0", res_resp[1]); end
      checks++; if (res_d[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL ws0_rdata: got %h exp deadbeef", res_d[1]); end
   endtask

   task automatic test_wait_states();
      use3 = 1'b1;
      set_op(0, 1'b0, 16'h0010, 3'd2, 32'h0);
      run_seq(1);
      checks++; if (res_waits[0] !== 3) begin errors++; $display("FAIL ws3_waits: got %0d exp 3", res_waits[0]); end
      checks++; if (res_r1[0] !== 1'b0 || res_resp[0] !== 1'b0) begin errors++; $display("FAIL ws3_resp: got %b/%b exp 0/0", res_r1[0], res_resp[0]); end
      checks++; if (res_d[0] !== mdl[1][4]) begin errors++; $display("FAIL ws3_rdata: got %h exp %h", res_d[0], mdl[1][4]); end
   endtask

   task automatic test_error();
      logic [15:0] ea [3];
      logic [2:0]  es [3];
      bit          ew [3];
      ea[0] = 16'h0400; es[0] = 3'd2; ew[0] = 1'b0;
      ea[1] = 16'h0400; es[1] = 3'd2; ew[1] = 1'b1;
      ea[2] = 16'h0020; es[2] = 3'd3; ew[2] = 1'b1;
      use3 = 1'b0;
      set_op(0, 1'b1, 16'h03FC, 3'd2, 32'hCAFEF00D);
      run_seq(1);
      model_write(0, 16'h03FC, 3'd2, 32'hCAFEF00D);
      for (int d = 0; d < 2; d++) begin
         use3 = (d == 1);
         for (int e = 0; e < 3; e++) begin
            set_op(0, ew[e], ea[e], es[e], 32'hFFFFFFFF);
            run_seq(1);
            checks++; if (res_r1[0] !== 1'b1 || res_waits[0] !== 1) begin errors++;
               $display("FAIL err1 dut%0d case%0d: resp=%b waits=%0d exp resp=1 waits=1", d, e, res_r1[0], res_waits[0]); end
            checks++; if (res_resp[0] !== 1'b1) begin errors++; $display("FAIL err2 dut%0d case%0d: resp=%b exp 1", d, e, res_resp[0]); end
         end
      end
      use3 = 1'b0;
      set_op(0, 1'b0, 16'h03FC, 3'd2, 32'h0);
      set_op(1, 1'b0, 16'h0020, 3'd2, 32'h0);
      run_seq(2);
      checks++; if (res_d[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL err_last_word: got %h exp cafef00d", res_d[0]); end
      checks++; if (res_d[1] !== mdl[0][8]) begin errors++; $display("FAIL err_size_nowrite: got %h exp %h", res_d[1], mdl[0][8]); end
   endtask

   task automatic test_byte_merge();
      use3 = 1'b0;
      set_op(0, 1'b1, 16'h0020, 3'd2, 32'h11223344);
      set_op(1, 1'b1, 16'h0021, 3'd0, 32'h0000AA00);
      set_op(2, 1'b0, 16'h0020, 3'd2, 32'h0);
      run_seq(3);
      model_write(0, 16'h0020, 3'd2, 32'h11223344);
      model_write(0, 16'h0021, 3'd0, 32'h0000AA00);
      checks++; if (res_d[2] !== 32'h1122AA44) begin errors++; $display("FAIL byte_merge: got %h exp 1122aa44", res_d[2]); end
      checks++; if (res_waits[2] !== 0) begin errors++; $display("FAIL byte_merge_waits: got %0d exp 0", res_waits[2]); end
   endtask

   task automatic test_back_to_back();
      for (int d = 0; d < 2; d++) begin
         use3 = (d == 1);
         set_op(0, 1'b1, 16'h0040, 3'd2, 32'h0);
         set_op(1, 1'b1, 16'h0042, 3'd1, 32'h55660000);
         set_op(2, 1'b1, 16'h0040, 3'd0, 32'h00000077);
         set_op(3, 1'b1, 16'h0041, 3'd0, 32'h00008800);
         set_op(4, 1'b0, 16'h0040, 3'd2, 32'h0);
         run_seq(5);
         for (int k = 0; k < 4; k++) model_write(d, op_a[k], op_s[k], op_d[k]);
         checks++; if (res_d[4] !== 32'h55668877) begin errors++; $display("FAIL b2b_merge dut%0d: got %h exp 55668877", d, res_d[4]); end
      end
   endtask

   task automatic test_random();
      int s, off;
      for (int d = 0; d < 2; d++) begin
         use3 = (d == 1);
         for (int k = 0; k < 48; k++) begin
            s   = $urandom_range(0, 2);
            off = (s == 2) ? 0 : (s == 1) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3);
            set_op(k, 1'($urandom_range(0, 1)), 16'(($urandom_range(0, 7) << 2) | off), 3'(s), $urandom);
         end
         run_seq(48);
         for (int k = 0; k < 48; k++) begin
            checks++; if (res_resp[k] !== 1'b0 || res_waits[k] !== 3 * d) begin errors++;
               $display("FAIL rnd_resp dut%0d op%0d: resp=%b waits=%0d exp 0/%0d", d, k, res_resp[k], res_waits[k], 3 * d); end
            if (op_w[k]) begin
               model_write(d, op_a[k], op_s[k], op_d[k]);
            end else begin
               checks++; if (res_d[k] !== mdl[d][op_a[k][9:2]]) begin errors++;
                  $display("FAIL rnd_rdata dut%0d op%0d addr %h: got %h exp %h", d, k, op_a[k], res_d[k], mdl[d][op_a[k][9:2]]); end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] old;
      old  = mdl[1][12];
      use3 = 1'b1;
      @(negedge HCLK);
      hsel = 1'b1; htrans = 2'b10; haddr = 16'h0030; hwrite = 1'b1; hsize = 3'd2;
      @(posedge HCLK); #1;
      htrans = 2'b00; hwdata = ~old;
      @(negedge HCLK);
      checks++; if (hro3 !== 1'b0) begin errors++; $display("FAIL rstmid_in_wait: hready got %b exp 0", hro3); end
      #1 HRESETn = 1'b0;
      #1;
      checks++; if (hro3 !== 1'b1 || hresp3 !== 1'b0) begin errors++;
         $display("FAIL rstmid_outputs: hready=%b hresp=%b exp 1/0", hro3, hresp3); end
      @(negedge HCLK); HRESETn = 1'b1;
      set_op(0, 1'b0, 16'h0030, 3'd2, 32'h0);
      run_seq(1);
      checks++; if (res_d[0] !== old) begin errors++; $display("FAIL rstmid_nocommit: got %h exp %h", res_d[0], old); end
   endtask

   initial begin
      test_reset();
      init_mem(0);
      init_mem(1);
      test_ws0_write_read();
      test_wait_states();
      test_error();
      test_byte_merge();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
